// File: rtl/coin_payout_if.sv
// ---------------------------------------------------------------------------
// coin_payout_if -- request/hopper/status bundle for the coin_payout block.
//
// Signals
//   start      : request to pay out 'amount' (sampled only in IDLE)
//   amount     : change to return, Rs0..31
//   coin_ack   : hopper has taken the presented coin
//   refill     : restock all denominations (honoured only in IDLE)
//   coin_out   : coin code 001=Rs1 010=Rs2 011=Rs5 100=Rs10 000=none
//   coin_valid : coin_out is valid
//   busy       : controller is not idle
//   done       : one-cycle pulse at the end of every request
//   short      : last request could not be fully paid
//   remaining  : amount still owed
//   empty      : per-denomination stock-empty flags {Rs10, Rs5, Rs2, Rs1}
//   state      : IDLE=00 SELECT=01 ISSUE=10 DONE=11
//
// Modports
//   master : the requester / hopper side (drives start, amount, coin_ack, refill)
//   slave  : the payout controller
// ---------------------------------------------------------------------------
interface coin_payout_if;
    logic       start;
    logic [4:0] amount;
    logic       coin_ack;
    logic       refill;
    logic [2:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       done;
    logic       short;
    logic [4:0] remaining;
    logic [3:0] empty;
    logic [1:0] state;

    modport master (
        output start, amount, coin_ack, refill,
        input  coin_out, coin_valid, busy, done, short, remaining, empty, state
    );

    modport slave (
        input  start, amount, coin_ack, refill,
        output coin_out, coin_valid, busy, done, short, remaining, empty, state
    );
endinterface

// File: rtl/coin_payout.sv
// ---------------------------------------------------------------------------
// coin_payout -- greedy change dispenser with per-denomination stock.
//
// Pays out a requested amount one coin at a time, always choosing the largest
// denomination that both fits in the amount still owed and is in stock. Each
// coin is presented on coin_out/coin_valid until the hopper acknowledges it.
// If no coin fits while money is still owed, the request ends with short=1.
//
// Ports
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (stocks return to INIT_STOCK)
//   bus   : coin_payout_if.slave -- request, hopper handshake and status
//
// Parameter
//   INIT_STOCK : coins per denomination after reset / refill (0..15)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module coin_payout #(
    parameter int INIT_STOCK = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    coin_payout_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SELECT = 2'b01;
    localparam logic [1:0] ST_ISSUE  = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    localparam logic [3:0] INIT_CNT = 4'(INIT_STOCK);

    // Denomination index 0..3 = Rs1, Rs2, Rs5, Rs10; coin code is index+1.
    function automatic logic [4:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_value = 5'd1;
            2'd1:    coin_value = 5'd2;
            2'd2:    coin_value = 5'd5;
            default: coin_value = 5'd10;
        endcase
    endfunction

    logic [1:0] state_q,      state_d;
    logic [2:0] coin_out_q,   coin_out_d;
    logic       coin_valid_q, coin_valid_d;
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic       short_q,      short_d;
    logic [4:0] remaining_q,  remaining_d;
    logic [3:0] empty_q,      empty_d;
    logic [1:0] sel_q,        sel_d;      // denomination being presented
    logic [3:0] stock_q [4];
    logic [3:0] stock_d [4];

    logic [3:0] eligible;
    logic       found;
    logic [1:0] pick;

    // A denomination is eligible when it fits in what is owed and is in
    // stock; this is what keeps both remaining and the stocks from wrapping.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_denom
            assign eligible[gi] = (stock_q[gi] != 4'd0) &&
                                  (coin_value(2'(gi)) <= remaining_q);
            assign empty_d[gi]  = (stock_d[gi] == 4'd0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stock_q[gi] <= INIT_CNT;
                end else begin
                    stock_q[gi] <= stock_d[gi];
                end
            end
        end
    endgenerate

    // Largest eligible denomination wins.
    always_comb begin
        found = (eligible != 4'b0000);
        pick  = 2'd0;
        if (eligible[3]) begin
            pick = 2'd3;
        end else if (eligible[2]) begin
            pick = 2'd2;
        end else if (eligible[1]) begin
            pick = 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        done_d       = 1'b0;
        short_d      = short_q;
        remaining_d  = remaining_q;
        sel_d        = sel_q;
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = stock_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                // Refill lands on the same edge that accepts start, so the
                // first SELECT already sees the restocked counters.
                if (bus.refill) begin
                    for (int i = 0; i < 4; i++) begin
                        stock_d[i] = INIT_CNT;
                    end
                end
                if (bus.start) begin
                    short_d     = 1'b0;
                    remaining_d = bus.amount;
                    if (bus.amount != 5'd0) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_SELECT: begin
                if (remaining_q == 5'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (found) begin
                    sel_d        = pick;
                    coin_out_d   = {1'b0, pick} + 3'd1;
                    coin_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    // Nothing fits: give up with the debt still recorded.
                    short_d = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_ISSUE: begin
                if (bus.coin_ack) begin
                    remaining_d    = remaining_q - coin_value(sel_q);
                    stock_d[sel_q] = stock_q[sel_q] - 4'd1;
                    coin_valid_d   = 1'b0;
                    coin_out_d     = 3'b000;
                    state_d        = ST_SELECT;
                end
            end

            default: begin  // ST_DONE: done is high for exactly this cycle
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            coin_out_q   <= 3'b000;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            remaining_q  <= 5'd0;
            empty_q      <= (INIT_CNT == 4'd0) ? 4'b1111 : 4'b0000;
            sel_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            remaining_q  <= remaining_d;
            empty_q      <= empty_d;
            sel_q        <= sel_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.coin_out   = coin_out_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.short      = short_q;
    assign bus.remaining  = remaining_q;
    assign bus.empty      = empty_q;

endmodule

// File: tb/tb_coin_payout.sv
// ---------------------------------------------------------------------------
// tb_coin_payout -- self-checking bench for coin_payout.
//
// A greedy change-making model (plain arithmetic on a stock array) predicts
// the coin sequence, shortfall, remaining debt and empty flags of every
// request. Two instances: the default (INIT_STOCK=15) and INIT_STOCK=1.
// Inputs are driven and outputs sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_coin_payout;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    coin_payout_if bus0 ();
    coin_payout_if bus1 ();

    coin_payout #(.INIT_STOCK(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    coin_payout #(.INIT_STOCK(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int total = 0;
    int bad   = 0;

    int val [4] = '{1, 2, 5, 10};   // Rs1, Rs2, Rs5, Rs10
    int m_stock [4];
    int m_rem;
    int m_short;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] m_empty();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
        return e;
    endfunction

    task automatic model_refill(input int n);
        for (int i = 0; i < 4; i++) m_stock[i] = n;
    endtask

    // One complete request on the default instance, checked cycle by cycle.
    task automatic do_req(input int amt, input bit with_refill,
                          input int dmin, input int dmax, input bit noise);
        int coins[$];
        int rem;
        int pick;
        int d;
        if (with_refill) model_refill(15);
        rem = amt;
        while (rem > 0) begin
            pick = -1;
            for (int i = 3; i >= 0; i--)
                if (pick < 0 && val[i] <= rem && m_stock[i] > 0) pick = i;
            if (pick < 0) break;
            coins.push_back(pick);
            m_stock[pick]--;
            rem -= val[pick];
        end

        bus0.start  = 1'b1;
        bus0.amount = 5'(amt);
        bus0.refill = with_refill;
        tick();
        bus0.start  = 1'b0;
        bus0.refill = 1'b0;
        bus0.amount = 5'($urandom_range(0, 31));
        chk("busy_after_start", bus0.busy, 1);

        if (amt == 0) begin
            chk("zero_done", bus0.done, 1);
            chk("zero_state", bus0.state, 3);
            chk("zero_no_coin", bus0.coin_valid, 0);
        end else begin
            chk("select_state", bus0.state, 1);
            foreach (coins[k]) begin
                tick();
                chk("coin_valid", bus0.coin_valid, 1);
                chk("coin_out", bus0.coin_out, coins[k] + 1);
                d = $urandom_range(dmin, dmax);
                for (int j = 0; j < d; j++) begin
                    if (noise && $urandom_range(0, 2) == 0) begin
                        bus0.start  = 1'b1;
                        bus0.amount = 5'($urandom_range(1, 31));
                        bus0.refill = 1'($urandom_range(0, 1));
                    end
                    tick();
                    bus0.start  = 1'b0;
                    bus0.refill = 1'b0;
                    chk("hold_valid", bus0.coin_valid, 1);
                    chk("hold_coin", bus0.coin_out, coins[k] + 1);
                end
                bus0.coin_ack = 1'b1;
                tick();
                bus0.coin_ack = 1'b0;
                chk("ack_drop_valid", bus0.coin_valid, 0);
                chk("ack_coin_none", bus0.coin_out, 0);
                chk("ack_state", bus0.state, 1);
            end
            tick();
            chk("done_pulse", bus0.done, 1);
            chk("done_state", bus0.state, 3);
            chk("remaining", bus0.remaining, rem);
        end
        m_rem   = rem;
        m_short = (rem > 0) ? 1 : 0;
        chk("short", bus0.short, m_short);

        tick();
        chk("done_one_cycle", bus0.done, 0);
        chk("idle_state", bus0.state, 0);
        chk("idle_busy", bus0.busy, 0);
        chk("empty", bus0.empty, m_empty());
        chk("short_hold", bus0.short, m_short);
        if (amt != 0) chk("remaining_hold", bus0.remaining, m_rem);
    endtask

    initial begin
        logic [2:0] exp1 [4];
        exp1[0] = 3'b100; exp1[1] = 3'b011; exp1[2] = 3'b010; exp1[3] = 3'b001;

        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.amount = 5'd0; bus0.coin_ack = 1'b0; bus0.refill = 1'b0;
        bus1.start = 1'b0; bus1.amount = 5'd0; bus1.coin_ack = 1'b0; bus1.refill = 1'b0;
        model_refill(15);
        m_rem = 0;
        m_short = 0;
        tick();
        tick();

        // Reset state
        chk("rst_state", bus0.state, 0);
        chk("rst_coin_out", bus0.coin_out, 0);
        chk("rst_valid", bus0.coin_valid, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_short", bus0.short, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_remaining", bus0.remaining, 0);
        chk("rst_empty", bus0.empty, 0);
        rst_n = 1'b1;
        tick();

        // 18 with full stock -> 10, 5, 2, 1
        do_req(18, 1'b0, 0, 0, 1'b0);
        // zero amount
        do_req(0, 1'b0, 0, 0, 1'b0);
        // 5 with a 10-cycle hopper stall
        do_req(5, 1'b0, 10, 10, 1'b0);

        // Drain Rs10, then 20 must come out as four Rs5 coins
        while (m_stock[3] > 0) do_req(10, 1'b0, 0, 1, 1'b0);
        chk("rs10_empty", bus0.empty[3], 1);
        do_req(20, 1'b0, 0, 1, 1'b0);
        bus0.refill = 1'b1;
        tick();
        bus0.refill = 1'b0;
        model_refill(15);
        chk("refill_empty", bus0.empty, 0);

        // Ack and refill outside ISSUE/IDLE rules
        bus0.coin_ack = 1'b1;
        tick();
        bus0.coin_ack = 1'b0;
        chk("idle_ack_ignored", bus0.state, 0);
        chk("idle_ack_no_coin", bus0.coin_valid, 0);

        // Drain Rs1, then reset during ISSUE
        while (m_stock[0] > 0) do_req(1, 1'b0, 0, 0, 1'b0);
        chk("rs1_empty", bus0.empty[0], 1);
        bus0.start  = 1'b1;
        bus0.amount = 5'd7;
        tick();
        bus0.start  = 1'b0;
        tick();
        chk("pre_rst_valid", bus0.coin_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_issue_valid", bus0.coin_valid, 0);
        chk("rst_issue_state", bus0.state, 0);
        chk("rst_issue_busy", bus0.busy, 0);
        chk("rst_issue_coin", bus0.coin_out, 0);
        chk("rst_issue_rem", bus0.remaining, 0);
        chk("rst_issue_empty", bus0.empty, 0);
        model_refill(15);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", bus0.done, 0);
            chk("rst_stay_idle", bus0.state, 0);
        end

        // INIT_STOCK=1 instance: 31 -> 10, 5, 2, 1 then short with 13 owed
        bus1.start  = 1'b1;
        bus1.amount = 5'd31;
        tick();
        bus1.start  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s1_valid", bus1.coin_valid, 1);
            chk("s1_coin", bus1.coin_out, exp1[k]);
            bus1.coin_ack = 1'b1;
            tick();
            bus1.coin_ack = 1'b0;
        end
        tick();
        chk("s1_done", bus1.done, 1);
        chk("s1_short", bus1.short, 1);
        chk("s1_remaining", bus1.remaining, 13);
        chk("s1_empty", bus1.empty, 4'b1111);
        tick();

        // Random requests with occasional refill and ignored noise
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus0.coin_ack = 1'b1;
                tick();
                bus0.coin_ack = 1'b0;
                chk("rand_idle_ack", bus0.state, 0);
            end
            do_req($urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), 0, 3, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
